// File: rtl/smol_lsu_pkg.sv
// smol_lsu_pkg: shared definitions for the SmolCore load/store unit.
//   - size encodings for byte/half/word requests
//   - FSM state enum used by smol_lsu
//   - lsu_misaligned(): alignment / legal-size check for a request
package smol_lsu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_CAP  = 3'd2,
    ST_WR   = 3'd3,
    ST_RESP = 3'd4
  } lsu_state_t;

  // Returns 1 when the request can never be served: size 3, or a half/word
  // whose low address bits do not sit on its natural boundary.
  function automatic logic lsu_misaligned(input logic [1:0] size,
                                          input logic [1:0] addr);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr[0];
      SZ_WORD: bad = (addr != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/smol_lane_align.sv
// smol_lane_align: combinational byte-lane steering for smol_lsu.
// Ports:
//   word        in  32  word returned by the data memory
//   addr        in   2  low byte-address bits of the request
//   size        in   2  SZ_BYTE / SZ_HALF / SZ_WORD
//   is_unsigned in   1  zero-extend sub-word loads
//   wdata       in  32  right-aligned store data
//   load_data   out 32  extracted and extended load value
//   store_word  out 32  word with the store lane merged in
module smol_lane_align
  import smol_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  logic [7:0]  byte_lane_s;
  logic [15:0] half_lane_s;
  logic        byte_sign_s;
  logic        half_sign_s;

  // Pick the addressed byte and half lanes out of the little-endian word.
  always_comb begin
    byte_lane_s = word[{addr, 3'b000} +: 8];
    half_lane_s = word[{addr[1], 4'b0000} +: 16];
    byte_sign_s = byte_lane_s[7] & ~is_unsigned;
    half_sign_s = half_lane_s[15] & ~is_unsigned;
  end

  // Extend the selected lane to 32 bits; word loads ignore is_unsigned.
  always_comb begin
    load_data = 32'd0;
    case (size)
      SZ_BYTE: load_data = {{24{byte_sign_s}}, byte_lane_s};
      SZ_HALF: load_data = {{16{half_sign_s}}, half_lane_s};
      SZ_WORD: load_data = word;
      default: load_data = 32'd0;
    endcase
  end

  // Overlay the low store bits onto the addressed lane of the old word.
  always_comb begin
    store_word = word;
    case (size)
      SZ_BYTE: store_word[{addr, 3'b000} +: 8]     = wdata[7:0];
      SZ_HALF: store_word[{addr[1], 4'b0000} +: 16] = wdata[15:0];
      SZ_WORD: store_word = wdata;
      default: store_word = word;
    endcase
  end

endmodule

// File: rtl/smol_lsu.sv
// smol_lsu: SmolCore memory-stage load/store unit.
// Accepts one byte/half/word load or store at a time, drives a word-only
// memory port with one-cycle read latency, and returns one response per
// request. Sub-word stores are done as read-modify-write.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   reqValid/reqReady             request handshake (ready only in IDLE)
//   reqWrite, reqSize,
//   reqUnsigned, reqAddr, reqWdata request fields
//   rspValid, rspData, rspErr     one-cycle response strobe and payload
//   memRead, memWrite, memAddr,
//   writeData, readData           data memory port; the memory indexes
//                                 words with memAddr[MEM_AW+1:2]
module smol_lsu
  import smol_lsu_pkg::*;
#(
  parameter int unsigned MEM_AW = 32'd5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic        reqWrite,
  input  logic [1:0]  reqSize,
  input  logic        reqUnsigned,
  input  logic [31:0] reqAddr,
  input  logic [31:0] reqWdata,
  output logic        rspValid,
  output logic [31:0] rspData,
  output logic        rspErr,
  output logic        memRead,
  output logic        memWrite,
  output logic [31:0] memAddr,
  output logic [31:0] writeData,
  input  logic [31:0] readData
);

  // The memory word index must fit inside the 32-bit byte address.
  if (MEM_AW < 32'd1 || MEM_AW > 32'd30) begin : g_mem_aw_check
    $error("smol_lsu: MEM_AW must be in 1..30");
  end

  lsu_state_t  state_r, next_s;

  logic        write_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  logic        ready_r;
  logic        rsp_valid_r;
  logic        rsp_err_r;
  logic [31:0] rsp_data_r;
  logic        mem_read_r;
  logic        mem_write_r;
  logic [31:0] mem_addr_r;
  logic [31:0] write_data_r;

  logic        accept_s;
  logic        req_err_s;
  logic        req_word_store_s;
  logic [31:0] load_data_s;
  logic [31:0] store_word_s;

  // Request decode for the IDLE-cycle accept.
  always_comb begin
    accept_s         = (state_r == ST_IDLE) & reqValid;
    req_err_s        = lsu_misaligned(reqSize, reqAddr[1:0]);
    req_word_store_s = reqWrite & (reqSize == SZ_WORD) & ~req_err_s;
  end

  // Next-state logic for the request sequencer.
  always_comb begin
    next_s = ST_IDLE;
    case (state_r)
      ST_IDLE: begin
        if (!reqValid) begin
          next_s = ST_IDLE;
        end else if (req_err_s) begin
          next_s = ST_RESP;
        end else if (req_word_store_s) begin
          next_s = ST_WR;
        end else begin
          next_s = ST_RD;
        end
      end
      ST_RD:   next_s = ST_CAP;
      ST_CAP:  next_s = write_r ? ST_WR : ST_RESP;
      ST_WR:   next_s = ST_RESP;
      ST_RESP: next_s = ST_IDLE;
      default: next_s = ST_IDLE;
    endcase
  end

  smol_lane_align u_lane_align (
    .word        (readData),
    .addr        (addr_r[1:0]),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .wdata       (wdata_r),
    .load_data   (load_data_s),
    .store_word  (store_word_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Request field latches, loaded on accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_r    <= 1'b0;
      size_r     <= SZ_BYTE;
      unsigned_r <= 1'b0;
      addr_r     <= 32'd0;
      wdata_r    <= 32'd0;
    end else if (accept_s) begin
      write_r    <= reqWrite;
      size_r     <= reqSize;
      unsigned_r <= reqUnsigned;
      addr_r     <= reqAddr;
      wdata_r    <= reqWdata;
    end
  end

  // Control outputs are registered copies of the decoded next state, so
  // they match the state they belong to with no combinational path out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r     <= 1'b1;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      ready_r     <= (next_s == ST_IDLE);
      mem_read_r  <= (next_s == ST_RD);
      mem_write_r <= (next_s == ST_WR);
      rsp_valid_r <= (next_s == ST_RESP);
    end
  end

  // Address and response payload. rspErr is only ever set by an erroring
  // accept (which goes straight to RESP), and rspData only by the load
  // capture in CAP, so both read as 0 in every other cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_r <= 32'd0;
      rsp_err_r  <= 1'b0;
      rsp_data_r <= 32'd0;
    end else begin
      if (next_s == ST_IDLE) begin
        mem_addr_r <= 32'd0;
      end else if (accept_s) begin
        mem_addr_r <= reqAddr;
      end
      rsp_err_r  <= accept_s & req_err_s;
      rsp_data_r <= ((state_r == ST_CAP) && !write_r) ? load_data_s : 32'd0;
    end
  end

  // Store word: straight from the request for word stores, merged with
  // the freshly read word for sub-word stores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      write_data_r <= 32'd0;
    end else if (accept_s && req_word_store_s) begin
      write_data_r <= reqWdata;
    end else if ((state_r == ST_CAP) && write_r) begin
      write_data_r <= store_word_s;
    end
  end

  assign reqReady  = ready_r;
  assign memRead   = mem_read_r;
  assign memWrite  = mem_write_r;
  assign memAddr   = mem_addr_r;
  assign writeData = write_data_r;
  assign rspValid  = rsp_valid_r;
  assign rspErr    = rsp_err_r;
  assign rspData   = rsp_data_r;

endmodule

// File: tb/tb_smol_lsu.sv
// tb_smol_lsu: self-checking bench for smol_lsu.
// A request-level model predicts, per accepted request, when the memory
// pulses and the response must appear and what they must carry; a compare
// process checks the DUT against it every cycle. Directed calls pin the
// model with hand-computed values.
module tb_smol_lsu;

  localparam int unsigned MEM_AW = 32'd5;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqValid, reqReady, reqWrite, reqUnsigned;
  logic [1:0]  reqSize;
  logic [31:0] reqAddr, reqWdata;
  logic        rspValid, rspErr;
  logic [31:0] rspData;
  logic        memRead, memWrite;
  logic [31:0] memAddr, writeData, readData;

  smol_lsu #(.MEM_AW(MEM_AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqUnsigned(reqUnsigned), .reqAddr(reqAddr),
    .reqWdata(reqWdata),
    .rspValid(rspValid), .rspData(rspData), .rspErr(rspErr),
    .memRead(memRead), .memWrite(memWrite), .memAddr(memAddr),
    .writeData(writeData), .readData(readData)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b, want %0b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory environment (word array, 1-cycle read) -------
  logic        pre_we = 1'b0;
  logic [4:0]  pre_idx = 5'd0;
  logic [31:0] pre_val = 32'd0;
  logic [31:0] mem [0:31];

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_val;
    if (memRead) readData <= mem[memAddr[MEM_AW+1:2]];
    if (memWrite) mem[memAddr[MEM_AW+1:2]] <= writeData;
  end

  // ---------------- request-level model ---------------------------------
  function automatic logic f_err(input logic [1:0] sz, input logic [31:0] a);
    int nbytes;
    if (sz == 2'd3) return 1'b1;
    nbytes = 1 << sz;
    return (a % nbytes) != 0;
  endfunction

  function automatic int f_lat(input logic w, input logic [1:0] sz, input logic [31:0] a);
    if (f_err(sz, a)) return 1;
    if (!w) return 3;
    if (sz == 2'd2) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] f_extract(input logic [31:0] w, input logic [1:0] a,
                                            input logic [1:0] sz, input logic uns);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> (8 * a)) & 32'h0000_00FF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> (16 * a[1])) & 32'h0000_FFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] f_merge(input logic [31:0] w, input logic [1:0] a,
                                          input logic [1:0] sz, input logic [31:0] wd);
    logic [31:0] m;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * a;
      m  = 32'h0000_00FF << sh;
    end else if (sz == 2'd1) begin
      sh = 16 * a[1];
      m  = 32'h0000_FFFF << sh;
    end else begin
      return wd;
    end
    return (w & ~m) | ((wd << sh) & m);
  endfunction

  logic [31:0] smem [0:31];
  int          busy_until, rsp_at, rd_at, wr_at;
  int          acc_cnt = 0;
  int          last_acc_cyc = 0;
  logic [31:0] m_addr, m_data, m_wdata;
  logic        m_err, m_store;
  logic        req_bad;
  logic [4:0]  req_idx;

  assign req_bad = f_err(reqSize, reqAddr);
  assign req_idx = reqAddr[MEM_AW+1:2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_until <= -1;
      rsp_at     <= -1;
      rd_at      <= -1;
      wr_at      <= -1;
    end else begin
      if (pre_we) smem[pre_idx] <= pre_val;
      if (reqValid && cyc > busy_until) begin
        acc_cnt      <= acc_cnt + 1;
        last_acc_cyc <= cyc;
        busy_until   <= cyc + f_lat(reqWrite, reqSize, reqAddr);
        rsp_at       <= cyc + f_lat(reqWrite, reqSize, reqAddr);
        rd_at        <= (req_bad || (reqWrite && reqSize == 2'd2)) ? -1 : cyc + 1;
        wr_at        <= (req_bad || !reqWrite) ? -1 : ((reqSize == 2'd2) ? cyc + 1 : cyc + 3);
        m_addr       <= reqAddr;
        m_err        <= req_bad;
        m_store      <= reqWrite;
        m_data       <= (reqWrite || req_bad) ? 32'd0
                        : f_extract(smem[req_idx], reqAddr[1:0], reqSize, reqUnsigned);
        m_wdata      <= f_merge(smem[req_idx], reqAddr[1:0], reqSize, reqWdata);
        if (reqWrite && !req_bad)
          smem[req_idx] <= f_merge(smem[req_idx], reqAddr[1:0], reqSize, reqWdata);
      end
    end
  end

  // ---------------- compare process -------------------------------------
  int          rsp_cnt = 0;
  int          mem_pulses = 0;
  int          last_rsp_cyc = 0;
  int          last_wr_cyc = 0;
  logic [31:0] last_rsp_data = 32'd0;
  logic [31:0] last_wr_data = 32'd0;
  logic        last_rsp_err = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        chk1("ready", reqReady, cyc > busy_until);
        chk1("rsp_valid", rspValid, cyc == rsp_at);
        chk1("mem_read", memRead, cyc == rd_at);
        chk1("mem_write", memWrite, cyc == wr_at);
        chk("mem_addr", memAddr, (cyc > busy_until) ? 32'd0 : m_addr);
        if (cyc == rsp_at) begin
          chk("rsp_data", rspData, m_data);
          chk1("rsp_err", rspErr, m_err);
          if (m_store && !m_err)
            chk("mem_word", mem[m_addr[MEM_AW+1:2]], smem[m_addr[MEM_AW+1:2]]);
        end
        if (cyc == wr_at) chk("write_data", writeData, m_wdata);
        if (rspValid) begin
          rsp_cnt++;
          last_rsp_cyc  = cyc;
          last_rsp_data = rspData;
          last_rsp_err  = rspErr;
        end
        if (memRead || memWrite) mem_pulses++;
        if (memWrite) begin
          last_wr_cyc  = cyc;
          last_wr_data = writeData;
        end
      end
    end
  end

  // ---------------- directed request with literal expectations ----------
  task automatic run_req(input logic w, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                         input int exp_wr_lat, input logic [31:0] exp_wd, input int exp_pulses);
    int n, a0, r0, p0, acc;
    n = 0;
    while (!reqReady && n < 20) begin @(posedge clk); #1; n++; end
    a0 = acc_cnt; r0 = rsp_cnt; p0 = mem_pulses;
    reqWrite = w; reqSize = sz; reqUnsigned = uns; reqAddr = a; reqWdata = wd;
    reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    chk_int("accepted", acc_cnt - a0, 1);
    acc = last_acc_cyc;
    n = 0;
    while (rsp_cnt == r0 && n < 12) begin @(posedge clk); #1; n++; end
    chk_int("rsp_count", rsp_cnt - r0, 1);
    chk("lit_rsp_data", last_rsp_data, exp_d);
    chk1("lit_rsp_err", last_rsp_err, exp_e);
    chk_int("lit_latency", last_rsp_cyc - acc, exp_lat);
    chk_int("lit_mem_pulses", mem_pulses - p0, exp_pulses);
    if (exp_wr_lat > 0) begin
      chk_int("lit_wr_latency", last_wr_cyc - acc, exp_wr_lat);
      chk("lit_write_data", last_wr_data, exp_wd);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0, r0, acc1, n;
    rst_n = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0;
    reqUnsigned = 1'b0; reqAddr = 32'd0; reqWdata = 32'd0;
    #1 rst_n = 1'b0;
    #2;
    chk1("rst_ready", reqReady, 1'b1);
    chk1("rst_rsp_valid", rspValid, 1'b0);
    chk1("rst_rsp_err", rspErr, 1'b0);
    chk("rst_rsp_data", rspData, 32'd0);
    chk1("rst_mem_read", memRead, 1'b0);
    chk1("rst_mem_write", memWrite, 1'b0);
    chk("rst_mem_addr", memAddr, 32'd0);
    chk("rst_write_data", writeData, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 32; i++) begin
      pre_we = 1'b1; pre_idx = 5'(i);
      pre_val = (i == 8) ? 32'h80FF_7F01 : 32'd0;
      @(posedge clk); #1;
    end
    pre_we = 1'b0;

    //      w     sz    uns   addr        wdata          exp_d          err  lat wr  exp_wd         pulses
    run_req(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 2, 1, 32'hDEAD_BEEF, 1);
    run_req(1'b0, 2'd2, 1'b0, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b0, 2'd2, 1'b1, 32'h10, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b0, 2'd0, 1'b0, 32'h20, 32'h0,         32'h0000_0001, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b0, 2'd0, 1'b0, 32'h21, 32'h0,         32'h0000_007F, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b0, 2'd0, 1'b0, 32'h22, 32'h0,         32'hFFFF_FFFF, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b0, 2'd0, 1'b0, 32'h23, 32'h0,         32'hFFFF_FF80, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b0, 2'd0, 1'b1, 32'h23, 32'h0,         32'h0000_0080, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b0, 2'd1, 1'b0, 32'h22, 32'h0,         32'hFFFF_80FF, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b1, 2'd0, 1'b0, 32'h21, 32'h0000_00AA, 32'h0000_0000, 1'b0, 4, 3, 32'h80FF_AA01, 2);
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0,         32'h80FF_AA01, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b0, 2'd1, 1'b1, 32'h20, 32'h0,         32'h0000_AA01, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b1, 2'd1, 1'b0, 32'h22, 32'hFFFF_1234, 32'h0000_0000, 1'b0, 4, 3, 32'h1234_AA01, 2);
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0,         32'h1234_AA01, 1'b0, 3, 0, 32'h0,         1);
    run_req(1'b0, 2'd2, 1'b0, 32'h22, 32'h0,         32'h0000_0000, 1'b1, 1, 0, 32'h0,         0);
    run_req(1'b1, 2'd1, 1'b0, 32'h13, 32'h5555,      32'h0000_0000, 1'b1, 1, 0, 32'h0,         0);
    run_req(1'b0, 2'd3, 1'b0, 32'h00, 32'h0,         32'h0000_0000, 1'b1, 1, 0, 32'h0,         0);

    // Back-to-back: reqValid held high across the busy period.
    a0 = acc_cnt;
    reqWrite = 1'b0; reqSize = 2'd2; reqUnsigned = 1'b0; reqAddr = 32'h10;
    reqValid = 1'b1;
    @(posedge clk); #1;
    chk_int("b2b_first_accept", acc_cnt - a0, 1);
    acc1 = last_acc_cyc;
    chk1("b2b_ready_drop", reqReady, 1'b0);
    reqSize = 2'd0; reqAddr = 32'h21;
    n = 0;
    while ((acc_cnt - a0) < 2 && n < 12) begin @(posedge clk); #1; n++; end
    reqValid = 1'b0;
    chk_int("b2b_second_accept", acc_cnt - a0, 2);
    chk_int("b2b_accept_gap", last_acc_cyc - acc1, 4);
    r0 = rsp_cnt; n = 0;
    while (rsp_cnt == r0 && n < 12) begin @(posedge clk); #1; n++; end
    chk("b2b_second_data", last_rsp_data, 32'hFFFF_FFAA);

    // Reset during CAP of a load: aborts with no response.
    r0 = rsp_cnt; a0 = acc_cnt;
    reqWrite = 1'b0; reqSize = 2'd2; reqAddr = 32'h20; reqValid = 1'b1;
    @(posedge clk); #1;
    reqValid = 1'b0;
    chk_int("mid_rst_accept", acc_cnt - a0, 1);
    chk1("mid_rst_rd_phase", memRead, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk1("mid_rst_mem_read", memRead, 1'b0);
    chk1("mid_rst_mem_write", memWrite, 1'b0);
    chk1("mid_rst_rsp_valid", rspValid, 1'b0);
    chk1("mid_rst_ready", reqReady, 1'b1);
    chk("mid_rst_mem_addr", memAddr, 32'd0);
    chk("mid_rst_write_data", writeData, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk_int("mid_rst_no_rsp", rsp_cnt - r0, 0);
    chk1("post_rst_ready", reqReady, 1'b1);
    run_req(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 32'h1234_AA01, 1'b0, 3, 0, 32'h0, 1);

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/smol_lsu.md
# smol_lsu

Load/store unit for SmolCore's memory stage. Accepts one byte/half/word load or store from the pipeline, drives the word-only data memory port (`memRead`/`memWrite`/`memAddr`/`writeData`, one-cycle registered `readData`), performs byte-lane extraction and sign extension for loads and read-modify-write for sub-word stores, and returns one response per request. One request is in flight at a time.

## Interface
- `MEM_AW`, 5, word-index bits used by the data memory (`memAddr[MEM_AW+1:2]`); upper address bits pass through unchecked
- `clk`  in  1  clock; all state updates on the rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `reqValid`  in  1  request present
- `reqReady`  out  1  block idle and able to accept; high only in IDLE
- `reqWrite`  in  1  1 = store, 0 = load
- `reqSize`  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- `reqUnsigned`  in  1  loads: zero-extend instead of sign-extend
- `reqAddr`  in  32  byte address
- `reqWdata`  in  32  store data, right-aligned
- `rspValid`  out  1  one-cycle response strobe; no backpressure
- `rspData`  out  32  load result (0 for stores and errors)
- `rspErr`  out  1  misaligned or illegal-size request
- `memRead`  out  1  memory read enable
- `memWrite`  out  1  memory write enable
- `memAddr`  out  32  latched request address
- `writeData`  out  32  full word to write
- `readData`  in  32  memory read data, valid the cycle after `memRead`

## Operation
- FSM states: IDLE, RD, CAP, WR, RESP.
- IDLE: `reqReady`=1. On `reqValid`, latch write, size, unsigned, addr, wdata and check alignment.
  - Error (size 3, half with `addr[0]`=1, word with `addr[1:0]`≠0): go to RESP with `rspErr`=1 and no memory access.
  - Word store: go to WR. Load or sub-word store: go to RD.
- RD: `memRead`=1. Go to CAP.
- CAP: `readData` is valid in this cycle.
  - Load: extract the lane, extend it, register it into `rspData`, then go to RESP.
  - Sub-word store: merge the store lane into `readData`, register the merged word as `writeData`, then go to WR.
- WR: `memWrite`=1. Go to RESP.
- RESP: `rspValid`=1 for exactly one cycle. Go to IDLE.
- Lanes are little-endian:
  - Byte k = `addr[1:0]`, located at bits [8k+7:8k].
  - Half h = `addr[1]`, located at bits [16h+15:16h].
  - Store data comes from `reqWdata[7:0]` for bytes and `reqWdata[15:0]` for halves.
- Sign extension copies the MSB of the extracted lane unless `reqUnsigned`. Word loads ignore `reqUnsigned`.
- `memRead` and `memWrite` decode from state only and are never both high.
- `memAddr` holds the latched address in every state except IDLE. In IDLE it is 0.
- Holding `reqValid` high during a busy period has no effect. The next request is accepted on the first IDLE cycle after RESP.

## Timing
- Reset (asynchronous, immediate):
  - State goes to IDLE.
  - `reqReady`=1 once in IDLE.
  - `rspValid`, `rspErr`, `memRead`, `memWrite`=0.
  - `rspData`, `memAddr`, `writeData`=0.
- Reset mid-operation aborts the request with no response.
  - If asserted during WR, the write may or may not land. The bench must not check the memory word in that case.
- Latency, counted in cycles from the accept edge to the `rspValid` cycle:
  - Error: 1.
  - Word store: 2.
  - Load: 3.
  - Sub-word store: 4.
- Issue rate: one request per (latency + 1) cycles, because IDLE always takes one cycle.
- `rspData` and `rspErr` stay valid only while `rspValid`=1. Both clear to 0 on leaving RESP.

## Structure
- The package `smol_lsu_pkg` holds:
  - the size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`;
  - the state enum `lsu_state_t`;
  - the function `lsu_misaligned(size, addr)`.
- The sub-module `smol_lane_align` is combinational.
  - Inputs: word, addr[1:0], size, unsigned, wdata.
  - Outputs: extended load value and merged store word.
  - It is instantiated once and feeds both CAP paths.
- Top level: FSM, request latches, memory port decode.

## Test plan
- Word store then word load: store 0xDEADBEEF @0x10, then load @0x10.
  - Required: `memWrite` 1 cycle after accept with `writeData`=0xDEADBEEF; the load returns `rspData`=0xDEADBEEF 3 cycles after its accept, `rspErr`=0.
- Byte loads: memory word @0x20=0x80FF7F01.
  - Signed byte loads @0x20..0x23 return 0x00000001, 0x0000007F, 0xFFFFFFFF, 0xFFFFFF80.
  - Unsigned byte load @0x23 returns 0x00000080.
  - Signed half load @0x22 returns 0xFFFF80FF.
- Sub-word store RMW: word @0x20=0x80FF7F01, store byte 0xAA @0x21.
  - Required: RD, CAP, then WR with `writeData`=0x80FFAA01; `rspValid` 4 cycles after accept.
- Misaligned and illegal requests: word load @0x22, half store @0x13, size 3 @0x0.
  - Required: each gives `rspErr`=1, `rspData`=0 one cycle after accept, and no `memRead`/`memWrite` pulse.
- Back-to-back handshake: hold `reqValid` high with two loads queued.
  - Required: `reqReady` drops after the first accept; the second is accepted on the IDLE cycle after RESP.
- Reset mid-operation: deassert `rst_n` during CAP of a load.
  - Required: `memRead`/`rspValid` go to 0 immediately and no response is issued; after release `reqReady`=1 and a new load completes normally.
